// File: rtl/alu_b_mux_pkg.sv
// Shared constants for the ALU B-operand source select.
// Every 3-bit select value is a defined source.
package alu_b_mux_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [2:0] {
    ALUB_SRCX_REG_B = 3'b000,
    ALUB_SRCX_U8    = 3'b001,
    ALUB_SRCX_S8    = 3'b010,
    ALUB_SRCX_U8H   = 3'b011,
    ALUB_SRCX_U4    = 3'b100,
    ALUB_SRCX_U4_0  = 3'b101,
    ALUB_SRCX_U6    = 3'b110,
    ALUB_SRCX_U6_0  = 3'b111
  } alub_srcx_e;

endpackage

// File: rtl/alu_b_mux_imm_gen.sv
// Purely combinational B-operand builder: picks the register value or
// assembles an immediate from the instruction fields.
module alu_b_mux_imm_gen
  import alu_b_mux_pkg::*;
(
  input  logic [DATA_W-1:0] alub_din,
  input  logic [2:0]        alub_srcx,
  input  logic [3:0]        arga_x,
  input  logic [3:0]        argb_x,
  input  logic [1:0]        ldsincf,
  output logic [DATA_W-1:0] alub_next
);

  logic [7:0] imm8;
  logic [5:0] imm6;

  assign imm8 = {arga_x, argb_x};
  assign imm6 = {ldsincf, argb_x};

  always_comb begin
    alub_next = alub_din;
    case (alub_srcx)
      ALUB_SRCX_REG_B: alub_next = alub_din;
      ALUB_SRCX_U8:    alub_next = {8'h00, imm8};
      ALUB_SRCX_S8:    alub_next = {{8{imm8[7]}}, imm8};
      // High byte comes from the instruction, low byte passes through.
      ALUB_SRCX_U8H:   alub_next = {imm8, alub_din[7:0]};
      ALUB_SRCX_U4:    alub_next = {12'h000, argb_x};
      ALUB_SRCX_U4_0:  alub_next = {11'h000, argb_x, 1'b0};
      ALUB_SRCX_U6:    alub_next = {10'h000, imm6};
      ALUB_SRCX_U6_0:  alub_next = {9'h000, imm6, 1'b0};
    endcase
  end

endmodule

// File: rtl/alu_b_mux.sv
// ALU B-operand select with a single registered output stage.
// Synchronous active-low reset clears the operand register.
module alu_b_mux
  import alu_b_mux_pkg::*;
(
  input  logic        CLK,
  input  logic        RESETN,
  input  logic [15:0] ALUB_DIN,
  input  logic [2:0]  ALUB_SRCX,
  input  logic [3:0]  ARGA_X,
  input  logic [3:0]  ARGB_X,
  input  logic [1:0]  LDSINCF,
  output logic [15:0] ALUB_DATA
);

  logic [DATA_W-1:0] alub_next;
  logic [DATA_W-1:0] alub_data_reg;

  alu_b_mux_imm_gen u_imm_gen (
    .alub_din  (ALUB_DIN),
    .alub_srcx (ALUB_SRCX),
    .arga_x    (ARGA_X),
    .argb_x    (ARGB_X),
    .ldsincf   (LDSINCF),
    .alub_next (alub_next)
  );

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      alub_data_reg <= '0;
    end else begin
      alub_data_reg <= alub_next;
    end
  end

  assign ALUB_DATA = alub_data_reg;

endmodule

// File: tb/tb_alu_b_mux.sv
// Self-checking bench for alu_b_mux: directed operand-select steps followed
// by randomized selects checked against an arithmetic reference model.
module tb_alu_b_mux;

  logic        CLK = 1'b0;
  logic        RESETN;
  logic [15:0] ALUB_DIN;
  logic [2:0]  ALUB_SRCX;
  logic [3:0]  ARGA_X;
  logic [3:0]  ARGB_X;
  logic [1:0]  LDSINCF;
  logic [15:0] ALUB_DATA;

  int checks   = 0;
  int failures = 0;
  logic [15:0] prev_exp;

  alu_b_mux dut (
    .CLK       (CLK),
    .RESETN    (RESETN),
    .ALUB_DIN  (ALUB_DIN),
    .ALUB_SRCX (ALUB_SRCX),
    .ARGA_X    (ARGA_X),
    .ARGB_X    (ARGB_X),
    .LDSINCF   (LDSINCF),
    .ALUB_DATA (ALUB_DATA)
  );

  always #5 CLK = ~CLK;

  // Reference model built from plain integer arithmetic on the field values.
  function automatic logic [15:0] ref_model(input int s, input int din,
                                            input int a, input int b, input int l);
    int v8, v6, r;
    v8 = a * 16 + b;
    v6 = l * 16 + b;
    case (s)
      0:       r = din;
      1:       r = v8;
      2:       r = (v8 >= 128) ? (v8 - 256 + 65536) : v8;
      3:       r = v8 * 256 + (din % 256);
      4:       r = b;
      5:       r = b * 2;
      6:       r = v6;
      default: r = v6 * 2;
    endcase
    return 16'(r);
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rn, input logic [2:0] s, input logic [15:0] din,
                       input logic [3:0] a, input logic [3:0] b, input logic [1:0] l);
    RESETN    = rn;
    ALUB_SRCX = s;
    ALUB_DIN  = din;
    ARGA_X    = a;
    ARGB_X    = b;
    LDSINCF   = l;
  endtask

  // Inputs change mid-cycle: output must hold its old value until the edge,
  // then show the new value one cycle later.
  task automatic step(input string tag, input logic [2:0] s, input logic [15:0] din,
                      input logic [3:0] a, input logic [3:0] b, input logic [1:0] l,
                      input logic [15:0] exp);
    drive(1'b1, s, din, a, b, l);
    #1;
    check({tag, "_hold"}, ALUB_DATA, prev_exp);
    @(posedge CLK);
    #1;
    check(tag, ALUB_DATA, exp);
    $display("step %-10s srcx=%0d din=%h a=%h b=%h l=%b -> %h (exp %h)",
             tag, s, din, a, b, l, ALUB_DATA, exp);
    prev_exp = exp;
  endtask

  initial begin
    logic [2:0]  rs;
    logic [15:0] rdin;
    logic [3:0]  ra, rb;
    logic [1:0]  rl;
    logic        rrst;
    logic [15:0] rexp;

    drive(1'b0, 3'b000, 16'h1234, 4'h0, 4'h0, 2'b00);
    @(posedge CLK); #1;
    check("reset_1", ALUB_DATA, 16'h0000);
    @(posedge CLK); #1;
    check("reset_2", ALUB_DATA, 16'h0000);
    $display("reset held 2 cycles -> %h", ALUB_DATA);
    prev_exp = 16'h0000;

    step("rel_reset", 3'b000, 16'h1234, 4'h0, 4'h0, 2'b00, 16'h1234);
    step("reg_b",     3'b000, 16'h1234, 4'hA, 4'h5, 2'b10, 16'h1234);
    step("u8h",       3'b011, 16'h1234, 4'hA, 4'h5, 2'b10, 16'hA534);
    step("u8",        3'b001, 16'h1234, 4'h8, 4'h1, 2'b10, 16'h0081);
    step("s8_neg",    3'b010, 16'h1234, 4'h8, 4'h1, 2'b10, 16'hFF81);
    step("s8_pos",    3'b010, 16'h1234, 4'h4, 4'h1, 2'b10, 16'h0041);
    step("u4",        3'b100, 16'h1234, 4'h4, 4'h1, 2'b10, 16'h0001);
    step("u4_0",      3'b101, 16'h1234, 4'h4, 4'h1, 2'b10, 16'h0002);
    step("u6",        3'b110, 16'h1234, 4'h8, 4'hA, 2'b10, 16'h002A);
    step("u6_0",      3'b111, 16'h1234, 4'h8, 4'hA, 2'b10, 16'h0054);
    step("u6_0_arga", 3'b111, 16'hBEEF, 4'h3, 4'hA, 2'b10, 16'h0054);

    // Reset in mid-stream takes priority over a non-zero select.
    drive(1'b0, 3'b011, 16'hFFFF, 4'hF, 4'hF, 2'b11);
    @(posedge CLK); #1;
    check("reset_prio", ALUB_DATA, 16'h0000);
    prev_exp = 16'h0000;

    for (int i = 0; i < 300; i++) begin
      rs   = 3'($urandom_range(0, 7));
      rdin = 16'($urandom);
      ra   = 4'($urandom);
      rb   = 4'($urandom);
      rl   = 2'($urandom);
      rrst = ($urandom_range(0, 15) == 0);
      if (rrst) begin
        drive(1'b0, rs, rdin, ra, rb, rl);
        rexp = 16'h0000;
      end else begin
        drive(1'b1, rs, rdin, ra, rb, rl);
        rexp = ref_model(int'(rs), int'(rdin), int'(ra), int'(rb), int'(rl));
      end
      #1;
      check("rand_hold", ALUB_DATA, prev_exp);
      @(posedge CLK); #1;
      check("rand", ALUB_DATA, rexp);
      $display("rand %0d rst=%0d srcx=%0d din=%h a=%h b=%h l=%b -> %h (exp %h)",
               i, rrst, rs, rdin, ra, rb, rl, ALUB_DATA, rexp);
      prev_exp = rexp;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
